esc_ramp: RTL and testbench

//  Arming sequencer and slew-rate limiter between command source (SPI/host or sawtooth)
//  and the 'esc' pulse generator. Holds ESC at zero through an arming interval,

---
 rtl/esc_ramp_if.sv | 23 ++
 rtl/esc_ramp.sv | 191 +++++++++++++++++++
 tb/tb_esc_ramp.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/esc_ramp_if.sv
// Command/status bundle between the command source and esc_ramp.
// The master drives arm and commands; the slave returns the ESC value and status.
interface esc_ramp_if #(
  parameter int VAL_BITS = 10
);
  logic                arm;
  logic [VAL_BITS-1:0] cmd;
  logic                cmd_valid;
  logic [VAL_BITS-1:0] val;
  logic                armed;
  logic                busy;
  logic                wdog_trip;

  modport master (
    output arm, cmd, cmd_valid,
    input  val, armed, busy, wdog_trip
  );

  modport slave (
    input  arm, cmd, cmd_valid,
    output val, armed, busy, wdog_trip
  );
endinterface

// File: rtl/esc_ramp.sv
// Arming sequencer and slew-rate limiter that feeds the ESC pulse generator.
// Optional command watchdog is enabled by defining ESC_RAMP_WDOG_EN.
module esc_ramp #(
  parameter int VAL_BITS   = 10,
  parameter int ARM_TICKS  = 1000000,
  parameter int STEP_TICKS = 100,
  parameter int STEP       = 1,
  parameter int WDOG_TICKS = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  esc_ramp_if.slave   bus
);

  localparam int ARM_W  = $clog2(ARM_TICKS + 1);
  localparam int STEP_W = $clog2(STEP_TICKS + 1);

  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_TICKS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [VAL_BITS:0] STEP_MAG  = (VAL_BITS + 1)'(STEP);

  if (ARM_TICKS < 1 || STEP_TICKS < 1 || STEP < 1 || WDOG_TICKS < 1) begin : g_bad_param
    $error("esc_ramp: ARM_TICKS, STEP_TICKS, STEP and WDOG_TICKS must all be >= 1");
  end

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMING,
    ST_ARMED
  } state_t;

  state_t              state_q, state_d;
  logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [VAL_BITS-1:0] val_q, val_d;
  logic [VAL_BITS-1:0] target_q, target_d;
  logic                armed_q, armed_d;
  logic                busy_q, busy_d;

`ifdef ESC_RAMP_WDOG_EN
  localparam int                WDOG_W    = $clog2(WDOG_TICKS + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_TICKS - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              trip_q, trip_d;
`endif

  // One slew update: move toward tgt by at most STEP. The extra bit keeps
  // the differences from wrapping at the top of the range.
  function automatic logic [VAL_BITS-1:0] slew(input logic [VAL_BITS-1:0] cur,
                                               input logic [VAL_BITS-1:0] tgt);
    logic [VAL_BITS:0] c;
    logic [VAL_BITS:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c) begin
      return ((t - c) > STEP_MAG) ? VAL_BITS'(c + STEP_MAG) : tgt;
    end else if (c > t) begin
      return ((c - t) > STEP_MAG) ? VAL_BITS'(c - STEP_MAG) : tgt;
    end
    return cur;
  endfunction

  // NOTE: every _d signal gets its hold value first so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    step_cnt_d = step_cnt_q;
    val_d      = val_q;
    target_d   = target_q;
`ifdef ESC_RAMP_WDOG_EN
    wdog_cnt_d = '0;
    trip_d     = trip_q;
`endif

    unique case (state_q)
      ST_DISARMED: begin
        arm_cnt_d  = '0;
        step_cnt_d = '0;
        val_d      = '0;
        target_d   = '0;
`ifdef ESC_RAMP_WDOG_EN
        trip_d     = 1'b0;
`endif
        if (bus.arm) state_d = ST_ARMING;
      end

      ST_ARMING: begin
        if (!bus.arm) begin
          state_d   = ST_DISARMED;
          arm_cnt_d = '0;
        end else if (tick) begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d   = ST_ARMED;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
          end
        end
      end

      ST_ARMED: begin
        if (!bus.arm) begin
          // Disarm drops straight to zero, no ramp down.
          state_d    = ST_DISARMED;
          step_cnt_d = '0;
          val_d      = '0;
          target_d   = '0;
`ifdef ESC_RAMP_WDOG_EN
          trip_d     = 1'b0;
`endif
        end else begin
          if (bus.cmd_valid) target_d = bus.cmd;
          if (tick) begin
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_d = '0;
              // Uses the registered target: a coincident cmd_valid lands next update.
              val_d      = slew(val_q, target_q);
            end else begin
              step_cnt_d = step_cnt_q + STEP_W'(1);
            end
          end
`ifdef ESC_RAMP_WDOG_EN
          wdog_cnt_d = wdog_cnt_q;
          if (bus.cmd_valid) begin
            wdog_cnt_d = '0;
          end else if (tick) begin
            if (wdog_cnt_q == WDOG_LAST) begin
              wdog_cnt_d = '0;
              target_d   = '0;
              trip_d     = 1'b1;
            end else begin
              wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            end
          end
`endif
        end
      end

      default: state_d = ST_DISARMED;
    endcase

    armed_d = (state_d == ST_ARMED);
    busy_d  = armed_d && (val_d != target_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DISARMED;
      arm_cnt_q  <= '0;
      step_cnt_q <= '0;
      val_q      <= '0;
      target_q   <= '0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      step_cnt_q <= step_cnt_d;
      val_q      <= val_d;
      target_q   <= target_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
    end
  end

`ifdef ESC_RAMP_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      trip_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      trip_q     <= trip_d;
    end
  end

  assign bus.wdog_trip = trip_q;
`else
  assign bus.wdog_trip = 1'b0;
`endif

  assign bus.val   = val_q;
  assign bus.armed = armed_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_esc_ramp.sv
// Self-checking bench for esc_ramp: directed scenarios plus randomized traffic
// compared against a tick-level behavioural model.
module tb_esc_ramp;

  localparam int VAL_BITS   = 10;
  localparam int ARM_TICKS  = 10;
  localparam int STEP_TICKS = 2;
  localparam int STEP       = 4;
  localparam int WDOG_TICKS = 20;
  localparam int TICK_GAP   = 50;
  localparam int VAL_MAX    = (1 << VAL_BITS) - 1;

`ifdef ESC_RAMP_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic tick;

  esc_ramp_if #(.VAL_BITS(VAL_BITS)) bus ();

  esc_ramp #(
    .VAL_BITS  (VAL_BITS),
    .ARM_TICKS (ARM_TICKS),
    .STEP_TICKS(STEP_TICKS),
    .STEP      (STEP),
    .WDOG_TICKS(WDOG_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tracks ticks seen while arming / armed and applies the
  // slew rule once every STEP_TICKS armed ticks.
  bit m_arming, m_armed, m_trip;
  int m_val, m_target, m_arm_ticks, m_armed_ticks, m_idle;

  function automatic int toward(int v, int t);
    if (t > v) return (t - v > STEP) ? v + STEP : t;
    if (v > t) return (v - t > STEP) ? v - STEP : t;
    return v;
  endfunction

  function automatic void model_reset();
    m_arming = 0; m_armed = 0; m_trip = 0;
    m_val = 0; m_target = 0; m_arm_ticks = 0; m_armed_ticks = 0; m_idle = 0;
  endfunction

  function automatic void model_arm(bit a);
    if (!a) model_reset();
    else if (!m_armed && !m_arming) begin
      m_arming    = 1;
      m_arm_ticks = 0;
    end
  endfunction

  function automatic void model_cmd(int v);
    if (m_armed) begin
      m_target = v;
      m_idle   = 0;
    end
  endfunction

  function automatic void model_tick(bit with_cmd, int v);
    if (m_arming) begin
      m_arm_ticks++;
      if (m_arm_ticks == ARM_TICKS) begin
        m_arming = 0; m_armed = 1; m_armed_ticks = 0; m_idle = 0;
      end
    end else if (m_armed) begin
      m_armed_ticks++;
      if (m_armed_ticks % STEP_TICKS == 0) m_val = toward(m_val, m_target);
      if (with_cmd) begin
        m_target = v;
        m_idle   = 0;
      end else if (WDOG) begin
        m_idle++;
        if (m_idle == WDOG_TICKS) begin
          m_target = 0; m_trip = 1; m_idle = 0;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle gap-1 clocks, then one clock with the requested strobes.
  task automatic drive(bit t, bit c, int v, int gap);
    repeat (gap - 1) step();
    tick = t;
    bus.cmd_valid = c;
    bus.cmd = VAL_BITS'(v);
    step();
    tick = 1'b0;
    bus.cmd_valid = 1'b0;
    if (t) model_tick(c, v);
    else if (c) model_cmd(v);
  endtask

  task automatic do_tick(int gap);
    drive(1'b1, 1'b0, 0, gap);
  endtask

  task automatic do_cmd(int v);
    drive(1'b0, 1'b1, v, 1);
  endtask

  task automatic do_arm(bit a);
    bus.arm = a;
    step();
    model_arm(a);
  endtask

  task automatic arm_with_tick(bit a);
    bus.arm = a;
    tick = 1'b1;
    step();
    tick = 1'b0;
    model_arm(a);
  endtask

  task automatic test_reset();
    checks++; if (bus.val !== '0) begin errors++; $display("FAIL reset_val: got %0d expected 0", bus.val); end
    checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b expected 0", bus.armed); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.wdog_trip !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b expected 0", bus.wdog_trip); end
  endtask

  task automatic test_arming();
    arm_with_tick(1'b1);
    for (int i = 1; i <= ARM_TICKS; i++) begin
      do_tick(TICK_GAP);
      checks++; if (bus.armed !== m_armed) begin errors++; $display("FAIL arming_armed tick %0d: got %b expected %b", i, bus.armed, m_armed); end
      checks++; if (bus.val !== '0) begin errors++; $display("FAIL arming_val tick %0d: got %0d expected 0", i, bus.val); end
    end
    checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL arming_done: got %b expected 1", bus.armed); end

    do_arm(1'b0);
    checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL disarm: got %b expected 0", bus.armed); end
    do_arm(1'b1);
    repeat (4) do_tick(TICK_GAP);
    arm_with_tick(1'b0);
    do_arm(1'b1);
    for (int i = 1; i <= ARM_TICKS; i++) begin
      do_tick(TICK_GAP);
      checks++; if (bus.armed !== m_armed) begin errors++; $display("FAIL rearm_armed tick %0d: got %b expected %b", i, bus.armed, m_armed); end
    end
    checks++; if (bus.armed !== 1'b1) begin errors++; $display("FAIL rearm_done: got %b expected 1", bus.armed); end
  endtask

  task automatic test_ramp();
    int peak;
    peak = 0;
    do_cmd(10);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_start: got %b expected 1", bus.busy); end
    for (int i = 1; i <= 8; i++) begin
      do_tick(TICK_GAP);
      if (int'(bus.val) > peak) peak = int'(bus.val);
      checks++; if (bus.val !== VAL_BITS'(m_val)) begin errors++; $display("FAIL ramp_val tick %0d: got %0d expected %0d", i, bus.val, m_val); end
    end
    checks++; if (bus.val !== VAL_BITS'(10) || peak > 10) begin errors++; $display("FAIL ramp_final: got %0d peak %0d expected 10", bus.val, peak); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_saturate();
    do_cmd(1020);
    for (int i = 0; i < 700 && m_val != 1020; i++) do_tick(4);
    checks++; if (bus.val !== VAL_BITS'(m_val)) begin errors++; $display("FAIL sat_climb: got %0d expected %0d", bus.val, m_val); end
    do_cmd(VAL_MAX);
    for (int i = 1; i <= 6; i++) begin
      do_tick(4);
      checks++; if (bus.val !== VAL_BITS'(m_val)) begin errors++; $display("FAIL sat_top tick %0d: got %0d expected %0d", i, bus.val, m_val); end
    end
    do_cmd(0);
    for (int i = 0; i < 700 && m_val != 0; i++) begin
      do_tick(4);
      checks++; if (bus.val !== VAL_BITS'(m_val)) begin errors++; $display("FAIL sat_down tick %0d: got %0d expected %0d", i, bus.val, m_val); end
    end
    checks++; if (bus.val !== '0) begin errors++; $display("FAIL sat_floor: got %0d expected 0", bus.val); end
  endtask

  task automatic test_collision();
    do_cmd(8);
    for (int i = 0; i < 20 && m_val != 8; i++) do_tick(TICK_GAP);
    for (int i = 0; i < STEP_TICKS && (m_armed_ticks + 1) % STEP_TICKS != 0; i++) do_tick(TICK_GAP);
    drive(1'b1, 1'b1, 20, TICK_GAP);
    checks++; if (bus.val !== VAL_BITS'(8)) begin errors++; $display("FAIL collide_hold: got %0d expected 8", bus.val); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL collide_busy: got %b expected 1", bus.busy); end
    repeat (STEP_TICKS) do_tick(TICK_GAP);
    checks++; if (bus.val !== VAL_BITS'(12)) begin errors++; $display("FAIL collide_next: got %0d expected 12", bus.val); end
  endtask

  task automatic test_wdog();
    do_cmd(40);
    for (int i = 0; i < 40 && m_val != 40; i++) do_tick(TICK_GAP);
    do_cmd(40);
    for (int i = 1; i <= WDOG_TICKS + 25; i++) begin
      do_tick(TICK_GAP);
      checks++; if (bus.wdog_trip !== m_trip) begin errors++; $display("FAIL wdog_trip tick %0d: got %b expected %b", i, bus.wdog_trip, m_trip); end
      checks++; if (bus.val !== VAL_BITS'(m_val)) begin errors++; $display("FAIL wdog_val tick %0d: got %0d expected %0d", i, bus.val, m_val); end
    end
    checks++; if (bus.val !== VAL_BITS'(WDOG ? 0 : 40)) begin errors++; $display("FAIL wdog_final: got %0d expected %0d", bus.val, WDOG ? 0 : 40); end
    do_arm(1'b0);
    checks++; if (bus.wdog_trip !== 1'b0 || bus.val !== '0) begin errors++; $display("FAIL wdog_disarm: trip %b val %0d expected 0 0", bus.wdog_trip, bus.val); end
  endtask

  task automatic test_random();
    do_arm(1'b1);
    repeat (ARM_TICKS) do_tick(TICK_GAP);
    for (int n = 0; n < 200; n++) begin
      int r;
      int v;
      r = int'($urandom_range(0, 19));
      v = int'($urandom_range(0, VAL_MAX));
      if (r < 10) do_tick(int'($urandom_range(2, TICK_GAP)));
      else if (r < 14) do_cmd(v);
      else if (r < 18) drive(1'b1, 1'b1, v, int'($urandom_range(2, TICK_GAP)));
      else if (!m_armed && !m_arming) do_arm(1'b1);
      else if (r == 19 && $urandom_range(0, 3) == 0) do_arm(1'b0);
      else do_tick(TICK_GAP);
      checks++; if (bus.val !== VAL_BITS'(m_val)) begin errors++; $display("FAIL rand_val op %0d: got %0d expected %0d", n, bus.val, m_val); end
      checks++; if (bus.armed !== m_armed) begin errors++; $display("FAIL rand_armed op %0d: got %b expected %b", n, bus.armed, m_armed); end
      checks++; if (bus.busy !== (m_armed && m_val != m_target)) begin errors++; $display("FAIL rand_busy op %0d: got %b expected %b", n, bus.busy, m_armed && m_val != m_target); end
      checks++; if (bus.wdog_trip !== m_trip) begin errors++; $display("FAIL rand_wdog op %0d: got %b expected %b", n, bus.wdog_trip, m_trip); end
    end
  endtask

  task automatic test_async_reset();
    do_arm(1'b0);
    do_arm(1'b1);
    repeat (ARM_TICKS) do_tick(4);
    do_cmd(40);
    repeat (10) do_tick(4);
    do_cmd(40);
    repeat (10) do_tick(4);
    checks++; if (bus.val !== VAL_BITS'(m_val) || m_val != 40) begin errors++; $display("FAIL pre_reset_val: got %0d expected 40", bus.val); end
    #5 rst_n = 1'b0;
    #1;
    checks++; if (bus.val !== '0) begin errors++; $display("FAIL async_val: got %0d expected 0", bus.val); end
    checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL async_armed: got %b expected 0", bus.armed); end
    checks++; if (bus.wdog_trip !== 1'b0) begin errors++; $display("FAIL async_wdog: got %b expected 0", bus.wdog_trip); end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++; if (bus.armed !== 1'b0) begin errors++; $display("FAIL post_reset_armed: got %b expected 0", bus.armed); end
  endtask

  initial begin
    rst_n = 1'b1;
    tick = 1'b0;
    bus.arm = 1'b0;
    bus.cmd = '0;
    bus.cmd_valid = 1'b0;
    model_reset();
    #3 rst_n = 1'b0;
    #2;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    step();
    test_arming();
    test_ramp();
    test_saturate();
    test_collision();
    test_wdog();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete within 5 ms");
    $fatal(1, "timeout");
  end

endmodule
